rl_dmp_dccm_rmw_merge: RTL and testbench

Store-side read-modify-write stage of the DMP DCCM write path, directly upstream of the DCCM ECC encoder. It accepts byte-enabled 32-bit stores:

- Full-word stores are encoded and written straight away.
- Partial stores first read the protected word, merge the enabled bytes, re-encode with data and address, then write 40 bits (32 data + 8 ECC).

Uncorrectable read errors abort the write and are reported to the requester.

---
 rtl/rl_dmp_dccm_rmw_merge_pkg.sv | 33 +++
 rtl/rl_dmp_dccm_ecc_encoder.sv | 32 +++
 rtl/rl_dmp_dccm_rmw_merge.sv | 149 ++++++++++++++
 tb/tb_rl_dmp_dccm_rmw_merge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rl_dmp_dccm_rmw_merge_pkg.sv
// Shared DMP DCCM store-path definitions: geometry, RMW state encoding, byte merge.
package rl_dmp_dccm_rmw_merge_pkg;

    localparam int DCCM_DATA_W = 32;
    localparam int DCCM_ADDR_W = 17;
    localparam int DCCM_ECC_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_DONE,
        ST_ERR
    } state_e;

    // Byte i of the result comes from new_w when be[i] is set, else from old_w.
    function automatic logic [DCCM_DATA_W-1:0] byte_merge(
        input logic [DCCM_DATA_W-1:0]   old_w,
        input logic [DCCM_DATA_W-1:0]   new_w,
        input logic [DCCM_DATA_W/8-1:0] be
    );
        logic [DCCM_DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < DCCM_DATA_W/8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rl_dmp_dccm_ecc_encoder.sv
// DCCM check-bit generator over data and word address (combinational, no backpressure).
// ecc[5:0]: Hamming position parity, data bit j at position j+1, addr bit i at i+33; ecc[6]/ecc[7]: data/addr overall parity.
module rl_dmp_dccm_ecc_encoder
    import rl_dmp_dccm_rmw_merge_pkg::*;
(
    input  logic [DCCM_DATA_W-1:0] data,
    input  logic [DCCM_ADDR_W-1:0] addr,
    output logic [DCCM_ECC_W-1:0]  ecc
);

    logic [5:0] pos;

    always_comb begin
        ecc = '0;
        pos = '0;
        for (int j = 0; j < DCCM_DATA_W; j++) begin
            pos = 6'(j + 1);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) ecc[k] = ecc[k] ^ data[j];
            end
            ecc[6] = ecc[6] ^ data[j];
        end
        for (int i = 0; i < DCCM_ADDR_W; i++) begin
            pos = 6'(i + 33);
            for (int k = 0; k < 6; k++) begin
                if (pos[k]) ecc[k] = ecc[k] ^ addr[i];
            end
            ecc[7] = ecc[7] ^ addr[i];
        end
    end

endmodule

// File: rtl/rl_dmp_dccm_rmw_merge.sv
// DCCM store read-modify-write: full words written directly, partial words read, merged, re-encoded.
// Optional held-word bypass for back-to-back partial stores: RL_DMP_DCCM_RMW_BYPASS_EN.
module rl_dmp_dccm_rmw_merge
    import rl_dmp_dccm_rmw_merge_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_a,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [DCCM_ADDR_W-1:0]             req_addr,
    input  logic [DCCM_DATA_W-1:0]             req_wdata,
    input  logic [DCCM_DATA_W/8-1:0]           req_be,
    output logic                               dccm_req,
    output logic                               dccm_we,
    output logic [DCCM_ADDR_W-1:0]             dccm_addr,
    output logic [DCCM_ECC_W+DCCM_DATA_W-1:0]  dccm_wdata,
    input  logic                               dccm_gnt,
    input  logic                               rd_valid,
    input  logic [DCCM_DATA_W-1:0]             rd_data,
    input  logic                               rd_dbe,
    output logic                               done_valid,
    output logic                               done_err,
    input  logic                               bypass_inv
);

    state_e                   state_q, state_d;
    logic [DCCM_ADDR_W-1:0]   addr_q, addr_d;
    logic [DCCM_DATA_W-1:0]   word_q, word_d;
    logic [DCCM_DATA_W/8-1:0] be_q, be_d;
    logic [DCCM_ECC_W-1:0]    ecc;
    logic                     byp_hit;
    logic [DCCM_DATA_W-1:0]   byp_word;

`ifdef RL_DMP_DCCM_RMW_BYPASS_EN
    logic                   held_vld_q, held_vld_d;
    logic [DCCM_ADDR_W-1:0] held_addr_q, held_addr_d;
    logic [DCCM_DATA_W-1:0] held_word_q, held_word_d;

    assign byp_hit  = held_vld_q && !bypass_inv && (held_addr_q == req_addr);
    assign byp_word = held_word_q;

    // An external invalidate wins over a write completing in the same cycle.
    always_comb begin
        held_vld_d  = held_vld_q;
        held_addr_d = held_addr_q;
        held_word_d = held_word_q;
        if (state_q == ST_WR && dccm_gnt) begin
            held_vld_d  = 1'b1;
            held_addr_d = addr_q;
            held_word_d = word_q;
        end
        if (state_q == ST_ERR || bypass_inv) begin
            held_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            held_vld_q  <= 1'b0;
            held_addr_q <= '0;
            held_word_q <= '0;
        end else begin
            held_vld_q  <= held_vld_d;
            held_addr_q <= held_addr_d;
            held_word_q <= held_word_d;
        end
    end
`else
    logic unused_bypass_inv;
    assign unused_bypass_inv = bypass_inv;
    assign byp_hit           = 1'b0;
    assign byp_word          = '0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        be_d    = be_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    word_d = req_wdata;
                    be_d   = req_be;
                    if (req_be == 4'hF) begin
                        state_d = ST_WR;
                    end else if (req_be == 4'h0) begin
                        state_d = ST_DONE;
                    end else if (byp_hit) begin
                        word_d  = byte_merge(byp_word, req_wdata, req_be);
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (dccm_gnt) state_d = ST_RWAIT;
            end
            ST_RWAIT: begin
                if (rd_valid) begin
                    if (rd_dbe) begin
                        state_d = ST_ERR;
                    end else begin
                        word_d  = byte_merge(rd_data, word_q, be_q);
                        state_d = ST_WR;
                    end
                end
            end
            ST_WR: begin
                if (dccm_gnt) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            be_q    <= be_d;
        end
    end

    rl_dmp_dccm_ecc_encoder u_ecc (
        .data (word_q),
        .addr (addr_q),
        .ecc  (ecc)
    );

    // Address and data come straight from flops, so they cannot move while a request waits for grant.
    assign req_ready  = (state_q == ST_IDLE);
    assign dccm_req   = (state_q == ST_RD) || (state_q == ST_WR);
    assign dccm_we    = (state_q == ST_WR);
    assign dccm_addr  = addr_q;
    assign dccm_wdata = {ecc, word_q};
    assign done_valid = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign done_err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_rl_dmp_dccm_rmw_merge.sv
// Directed bench for the DCCM RMW merge stage with a scoreboard of expected writes and completions.
module tb_rl_dmp_dccm_rmw_merge;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [16:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        dccm_req;
    logic        dccm_we;
    logic [16:0] dccm_addr;
    logic [39:0] dccm_wdata;
    logic        dccm_gnt = 1'b0;
    logic        rd_valid = 1'b0;
    logic [31:0] rd_data = '0;
    logic        rd_dbe = 1'b0;
    logic        done_valid;
    logic        done_err;
    logic        bypass_inv = 1'b0;

    rl_dmp_dccm_rmw_merge dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .dccm_req   (dccm_req),
        .dccm_we    (dccm_we),
        .dccm_addr  (dccm_addr),
        .dccm_wdata (dccm_wdata),
        .dccm_gnt   (dccm_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_dbe     (rd_dbe),
        .done_valid (done_valid),
        .done_err   (done_err),
        .bypass_inv (bypass_inv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] addr;
        logic [39:0] wdata;
    } wr_t;

    typedef struct {
        logic err;
        int   cyc;
    } dn_t;

    wr_t         wr_q[$];
    dn_t         dn_q[$];
    logic [31:0] mem [int];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_reads = 0;
    int n_writes = 0;
    int stall_cfg = 0;
    bit dbe_cfg = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Positions 1..32 carry data bits, 33..49 carry address bits.
    function automatic logic [7:0] ref_ecc(input logic [31:0] d, input logic [16:0] a);
        logic [7:0] e;
        logic       b;
        logic [5:0] p6;
        e = 8'h00;
        for (int p = 1; p <= 49; p++) begin
            b  = (p <= 32) ? d[p-1] : a[p-33];
            p6 = 6'(p);
            if (b) begin
                e[5:0] = e[5:0] ^ p6;
                if (p <= 32) e[6] = ~e[6];
                else         e[7] = ~e[7];
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & m) | (old_w & ~m);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [16:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
    endfunction

    // DCCM/arbiter model plus output monitor, all evaluated on the falling edge.
    bit          rd_flag = 1'b0;
    logic [16:0] rd_addr = '0;
    int          gcnt = 0;
    bit          prev_pend = 1'b0;
    logic [16:0] prev_addr = '0;
    logic [39:0] prev_wdata = '0;

    always @(negedge clk) begin
        if (!rst_a) begin
            dccm_gnt  = 1'b0;
            rd_valid  = 1'b0;
            rd_dbe    = 1'b0;
            rd_flag   = 1'b0;
            gcnt      = 0;
            prev_pend = 1'b0;
        end else begin
            rd_valid = rd_flag;
            rd_data  = rd_flag ? mem_rd(rd_addr) : 32'h0;
            rd_dbe   = rd_flag && dbe_cfg;
            rd_flag  = 1'b0;

            if (prev_pend && dccm_req) begin
                chk("stall_addr_stable", 64'(dccm_addr), 64'(prev_addr));
                chk("stall_wdata_stable", 64'(dccm_wdata), 64'(prev_wdata));
            end

            if (done_valid) begin
                if (dn_q.size() == 0) begin
                    chk("unexpected_done", 64'(done_valid), 64'(0));
                end else begin
                    dn_t e;
                    e = dn_q.pop_front();
                    chk("done_err", 64'(done_err), 64'(e.err));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end

            dccm_gnt = 1'b0;
            if (dccm_req) begin
                if (gcnt < stall_cfg) begin
                    gcnt++;
                end else begin
                    gcnt     = 0;
                    dccm_gnt = 1'b1;
                    if (dccm_we) begin
                        n_writes++;
                        if (wr_q.size() == 0) begin
                            chk("unexpected_write", 64'(dccm_we), 64'(0));
                        end else begin
                            wr_t w;
                            w = wr_q.pop_front();
                            chk("write_addr", 64'(dccm_addr), 64'(w.addr));
                            chk("write_data", 64'(dccm_wdata), 64'(w.wdata));
                        end
                        mem[int'(dccm_addr)] = dccm_wdata[31:0];
                    end else begin
                        n_reads++;
                        rd_flag = 1'b1;
                        rd_addr = dccm_addr;
                    end
                end
            end
            prev_pend  = dccm_req && !dccm_gnt;
            prev_addr  = dccm_addr;
            prev_wdata = dccm_wdata;
        end
    end

    task automatic do_store(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be,
                            input int lat, input logic exp_err, input logic exp_wr,
                            input logic [31:0] exp_word);
        int t;
        wr_t w;
        dn_t n;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_store", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        if (exp_wr) begin
            w.addr  = a;
            w.wdata = {ref_ecc(exp_word, a), exp_word};
            wr_q.push_back(w);
        end
        n.err = exp_err;
        n.cyc = cyc + lat;
        dn_q.push_back(n);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((dn_q.size() != 0 || !req_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("completion_timeout", 64'(dn_q.size()), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        chk({tag, "_dccm_req"}, 64'(dccm_req), 64'(0));
        chk({tag, "_dccm_we"}, 64'(dccm_we), 64'(0));
        chk({tag, "_dccm_addr"}, 64'(dccm_addr), 64'(0));
        chk({tag, "_dccm_wdata"}, 64'(dccm_wdata), 64'(0));
        chk({tag, "_done_valid"}, 64'(done_valid), 64'(0));
        chk({tag, "_done_err"}, 64'(done_err), 64'(0));
    endtask

    initial begin
        int r0;
        int w0;
        logic [31:0] exp_w;
        int byp_lat;
        int byp_reads;

`ifdef RL_DMP_DCCM_RMW_BYPASS_EN
        byp_lat   = 2;
        byp_reads = 0;
`else
        byp_lat   = 4;
        byp_reads = 1;
`endif

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_a = 1'b1;
        @(negedge clk);

        // Full-word store goes straight to write.
        r0 = n_reads;
        do_store(17'h00010, 32'hDEADBEEF, 4'hF, 2, 1'b0, 1'b1, 32'hDEADBEEF);
        wait_done();
        chk("full_no_read", 64'(n_reads - r0), 64'(0));

        // Partial store merges one byte into read data.
        mem[32'h20] = 32'h11223344;
        r0 = n_reads;
        exp_w = ref_merge(mem_rd(17'h00020), 32'h0000AB00, 4'b0010);
        do_store(17'h00020, 32'h0000AB00, 4'b0010, 4, 1'b0, 1'b1, exp_w);
        wait_done();
        chk("partial_one_read", 64'(n_reads - r0), 64'(1));
        chk("partial_mem", 64'(mem_rd(17'h00020)), 64'(32'h1122AB44));

        // Uncorrectable read aborts the store.
        mem[32'h30] = 32'h0BADF00D;
        dbe_cfg = 1'b1;
        w0 = n_writes;
        do_store(17'h00030, 32'h0000FFFF, 4'h3, 3, 1'b1, 1'b0, 32'h0);
        wait_done();
        dbe_cfg = 1'b0;
        chk("dbe_no_write", 64'(n_writes - w0), 64'(0));
        chk("dbe_mem_kept", 64'(mem_rd(17'h00030)), 64'(32'h0BADF00D));

        // Three missing grants in both RD and WR.
        mem[32'h1ABCD] = 32'hA5A5A5A5;
        stall_cfg = 3;
        exp_w = ref_merge(mem_rd(17'h1ABCD), 32'h12345678, 4'hC);
        do_store(17'h1ABCD, 32'h12345678, 4'hC, 10, 1'b0, 1'b1, exp_w);
        wait_done();
        stall_cfg = 0;

        // Zero byte enables complete without touching the DCCM.
        r0 = n_reads;
        w0 = n_writes;
        do_store(17'h00050, 32'hFFFFFFFF, 4'h0, 1, 1'b0, 1'b0, 32'h0);
        wait_done();
        chk("be0_no_read", 64'(n_reads - r0), 64'(0));
        chk("be0_no_write", 64'(n_writes - w0), 64'(0));

        // Reset while a write waits for grant drops it with no completion.
        stall_cfg = 1000;
        w0 = n_writes;
        do_store(17'h00060, 32'hCAFEF00D, 4'hF, 2, 1'b0, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        chk("pre_reset_in_wr", 64'({dccm_req, dccm_we}), 64'(2'b11));
        rst_a = 1'b0;
        wr_q.delete();
        dn_q.delete();
        #1;
        chk_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        stall_cfg = 0;
        repeat (5) @(negedge clk);
        chk("reset_dropped_write", 64'(n_writes - w0), 64'(0));
        do_store(17'h00060, 32'hCAFEF00D, 4'hF, 2, 1'b0, 1'b1, 32'hCAFEF00D);
        wait_done();
        chk("post_reset_mem", 64'(mem_rd(17'h00060)), 64'(32'hCAFEF00D));

        // Back-to-back partial stores to one address.
        mem[32'h70] = 32'h55667788;
        exp_w = ref_merge(mem_rd(17'h00070), 32'h000000AA, 4'h1);
        do_store(17'h00070, 32'h000000AA, 4'h1, 4, 1'b0, 1'b1, exp_w);
        wait_done();
        r0 = n_reads;
        exp_w = ref_merge(mem_rd(17'h00070), 32'h0000BB00, 4'h2);
        do_store(17'h00070, 32'h0000BB00, 4'h2, byp_lat, 1'b0, 1'b1, exp_w);
        wait_done();
        chk("second_store_reads", 64'(n_reads - r0), 64'(byp_reads));
        chk("two_byte_merge", 64'(mem_rd(17'h00070)), 64'(32'h5566BBAA));

        // Another agent overwrites the word and invalidates the held copy.
        @(negedge clk);
        mem[32'h70] = 32'h99887766;
        bypass_inv = 1'b1;
        @(negedge clk);
        bypass_inv = 1'b0;
        r0 = n_reads;
        exp_w = ref_merge(mem_rd(17'h00070), 32'h00CC0000, 4'h4);
        do_store(17'h00070, 32'h00CC0000, 4'h4, 4, 1'b0, 1'b1, exp_w);
        wait_done();
        chk("inv_forces_read", 64'(n_reads - r0), 64'(1));
        chk("inv_merge", 64'(mem_rd(17'h00070)), 64'(32'h99CC7766));

        repeat (3) @(negedge clk);
        chk("leftover_writes", 64'(wr_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
